// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Widest supported frame payload; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int MAX_WIDTH = 9;

  function automatic logic parity_bit(input logic [MAX_WIDTH-1:0] data,
                                      input logic                 ptype);
    return (ptype == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; the head word is read
// directly from the storage flops so it is valid whenever !empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy update; simultaneous push and pop cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO front end, internal baud timing,
// runtime parity and stop-bit selection latched per frame.
//
// state  | meaning
// IDLE   | line high, waiting for a buffered word
// START  | start bit (low)
// DATA   | WIDTH data bits, LSB first
// PARITY | optional parity bit
// STOP   | one or two stop bits (high); may chain straight into START
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int DIV_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [DIV_WIDTH-1:0]   Baud_div,
  input  logic                   Parity_EN,
  input  logic                   Parity_type,
  input  logic                   Stop_two,
  input  logic                   In_valid,
  input  logic [WIDTH-1:0]       In_data,
  output logic                   In_ready,
  output logic                   Tx_out,
  output logic                   Busy,
  output logic [$clog2(DEPTH):0] Fifo_count,
  output logic                   Frame_done
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic                   par_bit_q, par_bit_d;
  logic                   par_en_q, par_en_d;
  logic                   stop_two_q, stop_two_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   tx_q, tx_d;

  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [WIDTH-1:0]       fifo_rd_data;
  logic [DIV_WIDTH-1:0]   eff_div;
  logic                   bit_end;
  logic                   load;

  uart_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .reset   (Reset),
    .push    (In_valid),
    .wr_data (In_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (Fifo_count)
  );

  assign eff_div  = (Baud_div == '0) ? DIV_WIDTH'(1) : Baud_div;
  assign bit_end  = (cnt_q == '0);
  assign In_ready = !fifo_full;
  assign Tx_out   = tx_q;
  assign Busy     = (state_q != IDLE);

  // Next-state, bit timing and frame loading; a pop latches the config.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    stop_two_d = stop_two_q;
    div_d      = div_q;
    cnt_d      = bit_end ? (div_q - DIV_WIDTH'(1)) : (cnt_q - DIV_WIDTH'(1));
    bit_d      = bit_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    Frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = cnt_q;
        load  = !fifo_empty;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(WIDTH - 1)) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = STOP;
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_two_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            Frame_done = 1'b1;
            state_d    = IDLE;
            tx_d       = 1'b1;
            load       = !fifo_empty;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      fifo_pop   = 1'b1;
      state_d    = START;
      tx_d       = 1'b0;
      shreg_d    = fifo_rd_data;
      par_bit_d  = parity_bit(MAX_WIDTH'(fifo_rd_data), Parity_type);
      par_en_d   = Parity_EN;
      stop_two_d = Stop_two;
      div_d      = eff_div;
      cnt_d      = eff_div - DIV_WIDTH'(1);
    end
  end

  // State register; reset aborts any frame and forces the line high.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      stop_two_q <= 1'b0;
      div_q      <= DIV_WIDTH'(1);
      cnt_q      <= '0;
      bit_q      <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      stop_two_q <= stop_two_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered. The reference model keeps a
// queue of buffered words and a queue of expected line samples (one per
// clock), built from the frame format when a word leaves the buffer.
module tb_uart_tx_buffered;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int DIV_WIDTH = 16;

  logic                 CLK = 1'b0;
  logic                 Reset = 1'b1;
  logic [DIV_WIDTH-1:0] Baud_div = 16'd1;
  logic                 Parity_EN = 1'b0;
  logic                 Parity_type = 1'b0;
  logic                 Stop_two = 1'b0;
  logic                 In_valid = 1'b0;
  logic [WIDTH-1:0]     In_data = '0;
  logic                 In_ready;
  logic                 Tx_out;
  logic                 Busy;
  logic [2:0]           Fifo_count;
  logic                 Frame_done;
  logic [6:0]           obs;

  int checks = 0;
  int failures = 0;

  bit         m_line[$];
  logic [7:0] m_fifo[$];

  uart_tx_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_WIDTH(DIV_WIDTH)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Baud_div    (Baud_div),
    .Parity_EN   (Parity_EN),
    .Parity_type (Parity_type),
    .Stop_two    (Stop_two),
    .In_valid    (In_valid),
    .In_data     (In_data),
    .In_ready    (In_ready),
    .Tx_out      (Tx_out),
    .Busy        (Busy),
    .Fifo_count  (Fifo_count),
    .Frame_done  (Frame_done)
  );

  always #5 CLK = ~CLK;

  assign obs = {Tx_out, Busy, Frame_done, In_ready, Fifo_count};

  // Expand one word into its per-cycle line samples using the current config.
  function automatic void add_frame(input logic [7:0] w);
    bit bits[$];
    int div;
    div = (Baud_div == 0) ? 1 : int'(Baud_div);
    bits.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) bits.push_back(w[i]);
    if (Parity_EN) bits.push_back((($countones(w) % 2) == 1) ^ Parity_type);
    bits.push_back(1'b1);
    if (Stop_two) bits.push_back(1'b1);
    foreach (bits[i])
      for (int k = 0; k < div; k++) m_line.push_back(bits[i]);
  endfunction

  always @(posedge CLK) begin : p_model
    int pre;
    logic [7:0] w;
    if (Reset) begin
      m_line.delete();
      m_fifo.delete();
    end else begin
      pre = m_fifo.size();
      if (m_line.size() > 0) void'(m_line.pop_front());
      if (m_line.size() == 0 && pre > 0) begin
        w = m_fifo.pop_front();
        add_frame(w);
      end
      if (In_valid && pre < DEPTH) m_fifo.push_back(In_data);
    end
  end

  function automatic logic [6:0] exp_outs();
    logic tx;
    logic [2:0] cnt;
    tx  = (m_line.size() > 0) ? m_line[0] : 1'b1;
    cnt = 3'(m_fifo.size());
    return {tx, (m_line.size() != 0), (m_line.size() == 1), (m_fifo.size() < DEPTH), cnt};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    In_valid = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    checks++;
    if (obs !== 7'b1001000) begin
      failures++;
      $display("FAIL reset_state obs=%b exp=%b", obs, 7'b1001000);
    end
    checks++;
    if (obs !== exp_outs()) begin
      failures++;
      $display("FAIL reset_model obs=%b exp=%b", obs, exp_outs());
    end
  endtask

  task automatic test_basic();
    int first = -1, done = -1, busy_n = 0;
    logic [9:0] seq = '0;
    Baud_div = 16'd4; Parity_EN = 1'b0; Parity_type = 1'b0; Stop_two = 1'b0;
    In_data = 8'hA5; In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      checks++;
      if (obs !== exp_outs()) begin
        failures++;
        $display("FAIL basic_model cyc=%0d obs=%b exp=%b", c, obs, exp_outs());
      end
      if (Busy) begin
        if (first < 0) first = c;
        busy_n++;
        if ((c - first) % 4 == 1 && (c - first) / 4 < 10) seq[(c - first) / 4] = Tx_out;
      end
      if (Frame_done) done = c;
      tick();
    end
    checks++;
    if (busy_n !== 40) begin
      failures++;
      $display("FAIL basic_busy_len got=%0d exp=40", busy_n);
    end
    checks++;
    if (done - first !== 39) begin
      failures++;
      $display("FAIL basic_done_pos got=%0d exp=39", done - first);
    end
    checks++;
    if (seq !== 10'b1101001010) begin
      failures++;
      $display("FAIL basic_bits got=%b exp=%b", seq, 10'b1101001010);
    end
  endtask

  task automatic test_parity();
    logic [7:0] words [3] = '{8'hA5, 8'hA5, 8'h01};
    logic       ptypes[3] = '{1'b0, 1'b1, 1'b0};
    logic       pexp  [3] = '{1'b0, 1'b1, 1'b1};
    for (int f = 0; f < 3; f++) begin
      int first = -1, busy_n = 0;
      logic pbit = 1'bx;
      Baud_div = 16'd2; Parity_EN = 1'b1; Parity_type = ptypes[f]; Stop_two = 1'b0;
      In_data = words[f]; In_valid = 1'b1;
      tick();
      In_valid = 1'b0;
      for (int c = 0; c < 30; c++) begin
        checks++;
        if (obs !== exp_outs()) begin
          failures++;
          $display("FAIL parity_model f=%0d cyc=%0d obs=%b exp=%b", f, c, obs, exp_outs());
        end
        if (Busy) begin
          if (first < 0) first = c;
          busy_n++;
          if (c - first == 18) pbit = Tx_out;
        end
        tick();
      end
      checks++;
      if (pbit !== pexp[f]) begin
        failures++;
        $display("FAIL parity_bit f=%0d got=%b exp=%b", f, pbit, pexp[f]);
      end
      checks++;
      if (busy_n !== 22) begin
        failures++;
        $display("FAIL parity_len f=%0d got=%0d exp=22", f, busy_n);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k = 0, n_done = 0, last_done = -1, busy_n = 0, first = -1, max_cnt = 0;
    bit saw_not_ready = 0;
    logic rdy;
    Baud_div = 16'd1; Parity_EN = 1'b0; Stop_two = 1'b0;
    for (int c = 0; c < 80; c++) begin
      checks++;
      if (obs !== exp_outs()) begin
        failures++;
        $display("FAIL b2b_model cyc=%0d obs=%b exp=%b", c, obs, exp_outs());
      end
      if (Busy) begin
        busy_n++;
        if (first < 0) first = c;
      end
      if (int'(Fifo_count) > max_cnt) max_cnt = int'(Fifo_count);
      if (!In_ready) saw_not_ready = 1;
      if (Frame_done) begin
        if (last_done >= 0) begin
          checks++;
          if (c - last_done !== 10) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d exp=10", c - last_done);
          end
        end
        last_done = c;
        n_done++;
      end
      In_valid = (k < 6);
      In_data = 8'h10 + 8'(k);
      rdy = In_ready;
      tick();
      if (In_valid && rdy) k++;
    end
    In_valid = 1'b0;
    checks++;
    if (n_done !== 6) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d exp=6", n_done);
    end
    checks++;
    if (busy_n !== 60) begin
      failures++;
      $display("FAIL b2b_busy_len got=%0d exp=60", busy_n);
    end
    checks++;
    if (first !== 2) begin
      failures++;
      $display("FAIL b2b_first_pop got=%0d exp=2", first);
    end
    checks++;
    if (max_cnt !== 4 || saw_not_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_full got=%0d/%0d exp=4/1", max_cnt, saw_not_ready);
    end
  endtask

  task automatic test_config_change();
    int first = -1, d1 = -1, d2 = -1, busy_n = 0;
    Baud_div = 16'd3; Parity_EN = 1'b0; Stop_two = 1'b1; Parity_type = 1'b0;
    In_data = 8'($urandom); In_valid = 1'b1;
    tick();
    In_data = 8'($urandom);
    tick();
    In_valid = 1'b0;
    for (int c = 0; c < 90; c++) begin
      checks++;
      if (obs !== exp_outs()) begin
        failures++;
        $display("FAIL cfg_model cyc=%0d obs=%b exp=%b", c, obs, exp_outs());
      end
      if (Busy) begin
        if (first < 0) first = c;
        busy_n++;
      end
      if (Frame_done) begin
        if (d1 < 0) d1 = c; else d2 = c;
      end
      if (first >= 0 && c == first + 6) begin
        Stop_two = 1'b0; Parity_EN = 1'b1; Baud_div = 16'd2;
      end
      tick();
    end
    checks++;
    if (d1 - first !== 32 || d2 - first !== 54) begin
      failures++;
      $display("FAIL cfg_done_pos got=%0d,%0d exp=32,54", d1 - first, d2 - first);
    end
    checks++;
    if (busy_n !== 55) begin
      failures++;
      $display("FAIL cfg_busy_len got=%0d exp=55", busy_n);
    end
  endtask

  task automatic test_reset_midframe();
    int activity = 0;
    Baud_div = 16'd2; Parity_EN = 1'b0; Stop_two = 1'b0;
    for (int i = 0; i < 3; i++) begin
      In_data = 8'($urandom); In_valid = 1'b1;
      tick();
    end
    In_valid = 1'b0;
    repeat (5) begin
      checks++;
      if (obs !== exp_outs()) begin
        failures++;
        $display("FAIL rstmid_model obs=%b exp=%b", obs, exp_outs());
      end
      tick();
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (obs !== 7'b1001000) begin
      failures++;
      $display("FAIL rstmid_state obs=%b exp=%b", obs, 7'b1001000);
    end
    for (int c = 0; c < 30; c++) begin
      checks++;
      if (obs !== exp_outs()) begin
        failures++;
        $display("FAIL rstmid_after cyc=%0d obs=%b exp=%b", c, obs, exp_outs());
      end
      if (Frame_done || !Tx_out || Busy) activity++;
      tick();
    end
    checks++;
    if (activity !== 0) begin
      failures++;
      $display("FAIL rstmid_quiet got=%0d exp=0", activity);
    end
  endtask

  task automatic test_div0();
    int busy_n = 0;
    Baud_div = 16'd0; Parity_EN = 1'b0; Stop_two = 1'b0;
    In_data = 8'($urandom); In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (obs !== exp_outs()) begin
        failures++;
        $display("FAIL div0_model cyc=%0d obs=%b exp=%b", c, obs, exp_outs());
      end
      if (Busy) busy_n++;
      tick();
    end
    checks++;
    if (busy_n !== 10) begin
      failures++;
      $display("FAIL div0_len got=%0d exp=10", busy_n);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      checks++;
      if (obs !== exp_outs()) begin
        failures++;
        $display("FAIL rand_model cyc=%0d obs=%b exp=%b", c, obs, exp_outs());
      end
      if (c < 600) begin
        In_valid    = ($urandom_range(0, 2) == 0);
        In_data     = 8'($urandom);
        Baud_div    = 16'($urandom_range(0, 3));
        Parity_EN   = 1'($urandom);
        Parity_type = 1'($urandom);
        Stop_two    = 1'($urandom);
      end else begin
        In_valid = 1'b0;
      end
      tick();
    end
    checks++;
    if (Busy !== 1'b0 || Fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL rand_drain busy=%b count=%0d exp=0/0", Busy, Fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_config_change();
    test_reset_midframe();
    test_div0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
